// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode map, immediate-format encoding,
// decoded-bundle field widths and the stage occupancy encoding.
package decode_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPC_W      = 7;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned F7_W       = 7;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned IMM_TYPE_W = 3;

  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic illegal;
  } dec_ctl_t;

  // Occupancy of the main register and skid entry.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bundle signals of the decode stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [decode_pkg::INSTR_W-1:0]       in_instr;
  logic [PC_W-1:0]                      in_pc;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [PC_W-1:0]                      out_pc;
  logic [decode_pkg::OPC_W-1:0]         out_opcode;
  logic [decode_pkg::F3_W-1:0]          out_funct3;
  logic [decode_pkg::F7_W-1:0]          out_funct7;
  logic [decode_pkg::REG_W-1:0]         out_rd;
  logic [decode_pkg::REG_W-1:0]         out_rs1;
  logic [decode_pkg::REG_W-1:0]         out_rs2;
  logic [XLEN-1:0]                      out_imm;
  decode_pkg::imm_type_e                out_imm_type;
  logic                                 out_uses_rs1;
  logic                                 out_uses_rs2;
  logic                                 out_writes_rd;
  logic                                 out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_imm_type,
           out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_imm_type,
           out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
  );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: format selection from the opcode and
// sign extension of the assembled 32-bit immediate to XLEN.
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm,
  output imm_type_e          imm_type
);

  logic [31:0] imm32;

  always_comb begin
    imm_type = IMM_NONE;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:                          imm_type = IMM_U;
      OPC_JAL:                                     imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM:  imm_type = IMM_I;
      OPC_STORE:                                   imm_type = IMM_S;
      OPC_BRANCH:                                  imm_type = IMM_B;
      default:                                     imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm        = {XLEN{imm32[31]}};
    imm[31:0]  = imm32;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with optional 2-entry skid buffer.
// The skid entry holds the raw word and is decoded again when it moves to main.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  decode_stage_if.slave   bus
);

  occ_e               state_q, state_d;
  logic               in_fire, out_fire, main_from_skid, load_main, load_skid;
  logic [INSTR_W-1:0] skid_instr_q, dec_instr;
  logic [PC_W-1:0]    skid_pc_q, dec_pc;
  logic [XLEN-1:0]    dec_imm;
  imm_type_e          dec_imm_type;
  dec_ctl_t           dec_ctl;
  logic [OPC_W-1:0]   opc;
  logic [F3_W-1:0]    f3;
  logic [F7_W-1:0]    f7;

  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (in_fire) state_d = OCC_MAIN;
      OCC_MAIN: begin
        if (in_fire && !out_fire)      state_d = OCC_FULL;
        else if (!in_fire && out_fire) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (out_fire) state_d = OCC_MAIN;
      default:   state_d = OCC_EMPTY;
    endcase
    if (flush) state_d = OCC_EMPTY;
  end

  // Without a skid entry, MAIN can only accept when it drains in the same cycle.
  always_comb begin
    bus.out_valid  = (state_q != OCC_EMPTY);
    bus.in_ready   = SKID ? (state_q != OCC_FULL) : ((state_q == OCC_EMPTY) || bus.out_ready);
    in_fire        = bus.in_valid && bus.in_ready;
    out_fire       = bus.out_valid && bus.out_ready;
    main_from_skid = (state_q == OCC_FULL) && out_fire;
    load_main      = !flush && (main_from_skid || (in_fire && ((state_q == OCC_EMPTY) || out_fire)));
    load_skid      = !flush && in_fire && (state_q == OCC_MAIN) && !out_fire;
  end

  assign dec_instr = (state_q == OCC_FULL) ? skid_instr_q : bus.in_instr;
  assign dec_pc    = (state_q == OCC_FULL) ? skid_pc_q    : bus.in_pc;
  assign opc       = dec_instr[6:0];
  assign f3        = dec_instr[14:12];
  assign f7        = dec_instr[31:25];

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (dec_instr),
    .imm      (dec_imm),
    .imm_type (dec_imm_type)
  );

  always_comb begin
    dec_ctl = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: dec_ctl.writes_rd = 1'b1;
      OPC_JALR: begin
        dec_ctl.uses_rs1  = 1'b1;
        dec_ctl.writes_rd = 1'b1;
        dec_ctl.illegal   = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_ctl.uses_rs1 = 1'b1;
        dec_ctl.uses_rs2 = 1'b1;
        dec_ctl.illegal  = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_ctl.uses_rs1  = 1'b1;
        dec_ctl.writes_rd = 1'b1;
        dec_ctl.illegal   = (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OPC_STORE: begin
        dec_ctl.uses_rs1 = 1'b1;
        dec_ctl.uses_rs2 = 1'b1;
        dec_ctl.illegal  = f3[2] || ((XLEN == 32) && (f3 == 3'b011));
      end
      OPC_OP_IMM: begin
        dec_ctl.uses_rs1  = 1'b1;
        dec_ctl.writes_rd = 1'b1;
      end
      OPC_OP: begin
        dec_ctl.uses_rs1  = 1'b1;
        dec_ctl.uses_rs2  = 1'b1;
        dec_ctl.writes_rd = 1'b1;
        dec_ctl.illegal   = !((f7 == 7'h00) || (f7 == 7'h20)) ||
                            ((f7 == 7'h20) && !((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_MISC_MEM: dec_ctl = '0;
      default:      dec_ctl.illegal = 1'b1;
    endcase
    if (dec_instr[1:0] != 2'b11) dec_ctl.illegal = 1'b1;
    if (dec_instr[11:7] == '0)   dec_ctl.writes_rd = 1'b0;
    if (dec_ctl.illegal) begin
      dec_ctl.uses_rs1  = 1'b0;
      dec_ctl.uses_rs2  = 1'b0;
      dec_ctl.writes_rd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (load_skid) begin
      skid_instr_q <= bus.in_instr;
      skid_pc_q    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_pc        <= '0;
      bus.out_opcode    <= '0;
      bus.out_funct3    <= '0;
      bus.out_funct7    <= '0;
      bus.out_rd        <= '0;
      bus.out_rs1       <= '0;
      bus.out_rs2       <= '0;
      bus.out_imm       <= '0;
      bus.out_imm_type  <= IMM_NONE;
      bus.out_uses_rs1  <= 1'b0;
      bus.out_uses_rs2  <= 1'b0;
      bus.out_writes_rd <= 1'b0;
      bus.out_illegal   <= 1'b0;
    end else if (load_main) begin
      bus.out_pc        <= dec_pc;
      bus.out_opcode    <= opc;
      bus.out_funct3    <= f3;
      bus.out_funct7    <= f7;
      bus.out_rd        <= dec_instr[11:7];
      bus.out_rs1       <= dec_instr[19:15];
      bus.out_rs2       <= dec_instr[24:20];
      bus.out_imm       <= dec_imm;
      bus.out_imm_type  <= dec_imm_type;
      bus.out_uses_rs1  <= dec_ctl.uses_rs1;
      bus.out_uses_rs2  <= dec_ctl.uses_rs2;
      bus.out_writes_rd <= dec_ctl.writes_rd;
      bus.out_illegal   <= dec_ctl.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: three decode_stage instances (RV32 skid, RV64 skid, RV32 no skid)
// driven from one shared stimulus; expected values are hand-computed constants.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(32)) bus_a ();
  decode_stage_if #(.XLEN(64), .PC_W(32)) bus_w ();
  decode_stage_if #(.XLEN(32), .PC_W(32)) bus_n ();

  assign bus_a.in_valid = in_valid;  assign bus_a.in_instr = in_instr;
  assign bus_a.in_pc    = in_pc;     assign bus_a.out_ready = out_ready;
  assign bus_w.in_valid = in_valid;  assign bus_w.in_instr = in_instr;
  assign bus_w.in_pc    = in_pc;     assign bus_w.out_ready = out_ready;
  assign bus_n.in_valid = in_valid;  assign bus_n.in_instr = in_instr;
  assign bus_n.in_pc    = in_pc;     assign bus_n.out_ready = out_ready;

  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b1)) u_dut   (.clk(clk), .rst(rst), .flush(flush), .bus(bus_a));
  decode_stage #(.XLEN(64), .PC_W(32), .SKID(1'b1)) u_dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus_w));
  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b0)) u_dut0  (.clk(clk), .rst(rst), .flush(flush), .bus(bus_n));

  // Legality table: {illegal on RV32, illegal on RV64, writes_rd on RV32}
  logic [31:0] lv_instr [0:12] = '{
    32'h00000000, 32'h00003003, 32'h023100B3, 32'h00001067, 32'h00002063,
    32'h00004023, 32'h40001033, 32'h403100B3, 32'h00006003, 32'h0000000F,
    32'h00000073, 32'h00000012, 32'h00000013};
  logic [2:0]  lv_exp [0:12] = '{
    3'b110, 3'b100, 3'b110, 3'b110, 3'b110,
    3'b110, 3'b110, 3'b001, 3'b100, 3'b000,
    3'b000, 3'b110, 3'b000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_in_ready",  bus_a.in_ready,  1'b1);
    chk("rst_out_pc",    bus_a.out_pc,    32'h0);
    chk("rst_out_imm",   bus_a.out_imm,   32'h0);
    chk("rst_illegal",   bus_a.out_illegal, 1'b0);
    chk("rst_n_ready",   bus_n.in_ready,  1'b1);

    // Field and immediate decodes
    issue(32'hFFF10093, 32'h1000);
    chk("addi_valid", bus_a.out_valid, 1'b1);
    chk("addi_pc",    bus_a.out_pc, 32'h1000);
    chk("addi_opc",   bus_a.out_opcode, 7'h13);
    chk("addi_imm",   bus_a.out_imm, 32'hFFFFFFFF);
    chk("addi_type",  bus_a.out_imm_type, IMM_I);
    chk("addi_rd",    bus_a.out_rd, 5'd1);
    chk("addi_rs1",   bus_a.out_rs1, 5'd2);
    chk("addi_urs1",  bus_a.out_uses_rs1, 1'b1);
    chk("addi_wrd",   bus_a.out_writes_rd, 1'b1);
    chk("addi_ill",   bus_a.out_illegal, 1'b0);

    issue(32'hFE512E23, 32'h1004);
    chk("sw_imm",   bus_a.out_imm, 32'hFFFFFFFC);
    chk("sw_type",  bus_a.out_imm_type, IMM_S);
    chk("sw_rs1",   bus_a.out_rs1, 5'd2);
    chk("sw_rs2",   bus_a.out_rs2, 5'd5);
    chk("sw_f3",    bus_a.out_funct3, 3'd2);
    chk("sw_f7",    bus_a.out_funct7, 7'h7F);
    chk("sw_urs2",  bus_a.out_uses_rs2, 1'b1);
    chk("sw_wrd",   bus_a.out_writes_rd, 1'b0);

    issue(32'hFE000CE3, 32'h1008);
    chk("beq_imm",   bus_a.out_imm, 32'hFFFFFFF8);
    chk("beq_type",  bus_a.out_imm_type, IMM_B);
    chk("beq_imm64", bus_w.out_imm, 64'hFFFFFFFF_FFFFFFF8);
    chk("beq_wrd",   bus_a.out_writes_rd, 1'b0);

    issue(32'h123451B7, 32'h100C);
    chk("lui_imm",   bus_a.out_imm, 32'h12345000);
    chk("lui_type",  bus_a.out_imm_type, IMM_U);
    chk("lui_imm64", bus_w.out_imm, 64'h00000000_12345000);
    chk("lui_rd",    bus_a.out_rd, 5'd3);
    chk("lui_urs1",  bus_a.out_uses_rs1, 1'b0);

    issue(32'h001000EF, 32'h1010);
    chk("jal_imm",  bus_a.out_imm, 32'h00000800);
    chk("jal_type", bus_a.out_imm_type, IMM_J);
    chk("jal_wrd",  bus_a.out_writes_rd, 1'b1);

    // Legality and register-use table
    for (int i = 0; i < 13; i++) begin
      issue(lv_instr[i], 32'h2000 + 32'(i) * 4);
      chk($sformatf("lv_valid[%0d]", i), bus_a.out_valid, 1'b1);
      chk($sformatf("lv_ill32[%0d]", i), bus_a.out_illegal, lv_exp[i][2]);
      chk($sformatf("lv_ill64[%0d]", i), bus_w.out_illegal, lv_exp[i][1]);
      chk($sformatf("lv_wrd[%0d]", i),   bus_a.out_writes_rd, lv_exp[i][0]);
      if (i == 2) begin
        chk("mul_urs1", bus_a.out_uses_rs1, 1'b0);
        chk("mul_urs2", bus_a.out_uses_rs2, 1'b0);
      end
    end
    tick();

    // Back-to-back stream of 8
    for (int i = 0; i <= 8; i++) begin
      in_valid  = (i < 8);
      in_pc     = 32'h200 + 32'(i) * 4;
      in_instr  = 32'h13 | (32'(i) << 7);
      out_ready = 1'b1;
      #1;
      if (i > 0) begin
        chk($sformatf("strm_valid[%0d]", i), bus_a.out_valid, 1'b1);
        chk($sformatf("strm_pc[%0d]", i),    bus_a.out_pc, 32'h200 + 32'(i - 1) * 4);
      end
      if (i < 8) chk($sformatf("strm_ready[%0d]", i), bus_a.in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("strm_drained", bus_a.out_valid, 1'b0);

    // Backpressure: out_ready low for 3 cycles
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'h13; out_ready = 1'b1; #1;
    chk("bp0_ready", bus_a.in_ready, 1'b1);
    tick();
    in_pc = 32'h304; out_ready = 1'b0; #1;
    chk("bp1_ready",   bus_a.in_ready, 1'b1);
    chk("bp1_pc",      bus_a.out_pc, 32'h300);
    chk("bp1_n_ready", bus_n.in_ready, 1'b0);
    tick();
    in_pc = 32'h308; #1;
    chk("bp2_ready",   bus_a.in_ready, 1'b0);
    chk("bp2_valid",   bus_a.out_valid, 1'b1);
    chk("bp2_pc",      bus_a.out_pc, 32'h300);
    chk("bp2_n_ready", bus_n.in_ready, 1'b0);
    tick();
    #1;
    chk("bp3_ready", bus_a.in_ready, 1'b0);
    chk("bp3_pc",    bus_a.out_pc, 32'h300);
    tick();
    out_ready = 1'b1; #1;
    chk("bp4_ready",   bus_a.in_ready, 1'b0);
    chk("bp4_pc",      bus_a.out_pc, 32'h300);
    chk("bp4_n_ready", bus_n.in_ready, 1'b1);
    chk("bp4_n_pc",    bus_n.out_pc, 32'h300);
    tick();
    #1;
    chk("bp5_ready", bus_a.in_ready, 1'b1);
    chk("bp5_pc",    bus_a.out_pc, 32'h304);
    tick();
    in_valid = 1'b0; #1;
    chk("bp6_valid", bus_a.out_valid, 1'b1);
    chk("bp6_pc",    bus_a.out_pc, 32'h308);
    tick();
    #1;
    chk("bp7_valid", bus_a.out_valid, 1'b0);

    // Flush with main and skid occupied plus a concurrent in_valid
    in_valid = 1'b1; in_pc = 32'h400; out_ready = 1'b0; #1;
    tick();
    in_pc = 32'h404; #1;
    chk("fl1_ready", bus_a.in_ready, 1'b1);
    tick();
    in_pc = 32'h408; flush = 1'b1; #1;
    chk("fl2_ready", bus_a.in_ready, 1'b0);
    chk("fl2_valid", bus_a.out_valid, 1'b1);
    tick();
    flush = 1'b0; in_pc = 32'h40C; out_ready = 1'b1; #1;
    chk("fl3_valid",   bus_a.out_valid, 1'b0);
    chk("fl3_ready",   bus_a.in_ready, 1'b1);
    chk("fl3_n_valid", bus_n.out_valid, 1'b0);
    tick();
    in_valid = 1'b0; #1;
    chk("fl4_valid", bus_a.out_valid, 1'b1);
    chk("fl4_pc",    bus_a.out_pc, 32'h40C);
    tick();
    #1;
    chk("fl5_valid", bus_a.out_valid, 1'b0);

    // Input accepted in the flush cycle is discarded
    in_valid = 1'b1; in_pc = 32'h500; flush = 1'b1; #1;
    chk("flacc_ready", bus_a.in_ready, 1'b1);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flacc_valid", bus_a.out_valid, 1'b0);
    tick();

    // Reset in the middle of a stall
    in_valid = 1'b1; in_pc = 32'h600; out_ready = 1'b0; #1;
    tick();
    in_pc = 32'h604; #1;
    tick();
    in_valid = 1'b0; rst = 1'b1; #1;
    chk("rs_pre_valid", bus_a.out_valid, 1'b1);
    tick();
    rst = 1'b0; #1;
    chk("rs_valid",   bus_a.out_valid, 1'b0);
    chk("rs_ready",   bus_a.in_ready, 1'b1);
    chk("rs_pc",      bus_a.out_pc, 32'h0);
    chk("rs_n_ready", bus_n.in_ready, 1'b1);
    out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
